led_fade_driver: RTL and testbench
==================================

Name: led_fade_driver

Overview:
- Downstream consumer of the mod-8 LED counter state bits.
- Converts each on/off bit into a PWM LED output whose brightness ramps (fades) toward the requested level, one step per tick strobe.
- Sits between the counter's S outputs and the RLED pins.
- The tick strobe comes from a prescaler-derived enable in the same clock domain; no derived clocks are used.

Parameters:
- N, 3, number of LED channels.
- PWM_W, 8, PWM and brightness width; MAX = 2^PWM_W - 1.
- STEP, 16, brightness change per tick. Legal range 1..MAX.

Ports:
- clk  input  1  system clock, 12 MHz on board.
- rst  input  1  synchronous, active-high reset.
- tick  input  1  single-cycle fade strobe, synchronous to clk.
- val  input  N  per-channel target: 1 = fade to full on, 0 = fade to off.
- led  output  N  registered PWM LED drive.
- settled  output  N  registered; channel brightness equals its current target endpoint.
- arrive  output  N  registered one-cycle pulse when a channel reaches its endpoint.
- busy  output  1  registered OR of ~settled.

Behaviour:
- Single clock domain. Reset is synchronous and active-high; all state updates on posedge clk.
- Reset values: bri[i]=0, pwm_cnt=0, led=0, settled=all 1s, arrive=0, busy=0.
- Reset asserted mid-fade: next edge forces the reset values regardless of tick/val.
- PWM counter:
  - PWM_W-bit, free-running, increments every cycle; wraps MAX -> 0.
  - Period 2^PWM_W cycles.
- Brightness update, per channel, only on cycles with tick=1. Direction is taken from val at that same edge.
  - val[i]=1 and bri<MAX: bri <= min(bri+STEP, MAX). Compute at PWM_W+1 bits, then saturate.
  - val[i]=0 and bri>0: bri <= max(bri-STEP, 0). Compute at PWM_W+1 bits signed, then clamp.
  - Already at endpoint: bri holds.
- tick=0: bri holds; val changes alone have no effect on bri.
- Reversal mid-fade: a val flip takes effect at the next tick and reverses direction from the current bri. No restart from an endpoint.
- Per-channel state, derived from bri and val (no separate register required):
  - OFF (bri=0, val=0)
  - RISING (val=1, bri<MAX)
  - ON (bri=MAX, val=1)
  - FALLING (val=0, bri>0)
- led[i], registered, 1-cycle latency from pwm_cnt/bri:
  - 1 when bri[i]=MAX (full-on, no dropout at pwm_cnt=MAX);
  - else 1 when bri[i] > pwm_cnt;
  - else 0.
  - bri=0 gives a constant 0.
- settled[i], registered every cycle: 1 when next-bri equals (val[i] ? MAX : 0). It drops the cycle after val changes away from the current endpoint.
- arrive[i]: 1 for exactly one cycle following a tick edge on which bri moved and landed on the val endpoint. Never asserted when bri was already at the endpoint, and never asserted from reset.
- busy = OR of ~settled, computed from the same next-state values and registered.
- Simultaneous tick and val change: the new val is used for that tick's direction.
- STEP not dividing MAX: the final step saturates, e.g. 240 -> 255 with STEP=16.

Test Plan:
- Reset behaviour: hold rst 3 cycles with tick=1, val=3'b111 -> led=0, bri=0, settled=3'b111, busy=0, arrive=0. After release, settled drops to 0 one cycle later (val=1, bri=0).
- Full fade-in, STEP=16, ch0 val=1: tick 16 times -> bri sequence 16, 32, ..., 240, 255. arrive[0] pulses once after tick 16; settled[0]=1 and busy=0 from then. Further ticks keep bri=255.
- Duty check: ch1 held at bri=64 (4 ticks from 0) -> over one 256-cycle PWM window led[1] high exactly 64 cycles. At bri=255, led[1] high all 256 cycles. At bri=0, high 0 cycles.
- Reversal: ch2 rising to bri=80 (5 ticks), then val[2]=0 -> next ticks give 64, 48, 32, 16, 0. arrive[2] pulses only after reaching 0; no pulse at the flip.
- Simultaneous edge: val[0] flips 1->0 on the same cycle as tick with bri=255 -> bri becomes 239; settled[0]=0 the next cycle; busy=1.
- Reset mid-fade: assert rst while bri=128 and pwm_cnt=77 -> next edge bri=0, pwm_cnt=0, led=0, arrive=0. No spurious arrive pulse after release.

Source files
------------

// File: rtl/led_fade_driver.sv
// led_fade_driver
//   Turns per-channel on/off requests into PWM LED drives whose brightness
//   ramps toward the requested endpoint by STEP on every tick strobe.
//
//   Ports:
//     clk      system clock
//     rst      synchronous, active-high reset
//     tick     single-cycle fade strobe (same clock domain)
//     val      per-channel target: 1 = fade to full on, 0 = fade to off
//     led      registered PWM drive per channel
//     settled  registered: channel brightness sits at its target endpoint
//     arrive   registered one-cycle pulse when a channel lands on its endpoint
//     busy     registered OR of ~settled
module led_fade_driver #(
  parameter int N     = 3,
  parameter int PWM_W = 8,
  parameter int STEP  = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         tick,
  input  logic [N-1:0] val,
  output logic [N-1:0] led,
  output logic [N-1:0] settled,
  output logic [N-1:0] arrive,
  output logic         busy
);

  localparam logic [PWM_W-1:0] MAX    = {PWM_W{1'b1}};
  localparam logic [PWM_W:0]   STEP_X = (PWM_W+1)'(STEP);

  // Rising step: one extra bit catches the carry, then clip at MAX.
  function automatic logic [PWM_W-1:0] sat_inc(input logic [PWM_W-1:0] b);
    logic [PWM_W:0] sum;
    sum = {1'b0, b} + STEP_X;
    return (sum > {1'b0, MAX}) ? MAX : sum[PWM_W-1:0];
  endfunction

  // Falling step: signed difference, clamp negative results to zero.
  function automatic logic [PWM_W-1:0] sat_dec(input logic [PWM_W-1:0] b);
    logic signed [PWM_W:0] diff;
    diff = $signed({1'b0, b}) - $signed(STEP_X);
    return (diff < 0) ? '0 : diff[PWM_W-1:0];
  endfunction

  logic [PWM_W-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [PWM_W-1:0] bri_q [N];
  logic [PWM_W-1:0] bri_d [N];
  logic [N-1:0]     led_q, led_d;
  logic [N-1:0]     settled_q, settled_d;
  logic [N-1:0]     arrive_q, arrive_d;
  logic             busy_q, busy_d;

  always_comb begin
    pwm_cnt_d = pwm_cnt_q + 1'b1;
    led_d     = '0;
    settled_d = '0;
    arrive_d  = '0;
    for (int i = 0; i < N; i++) begin
      bri_d[i] = bri_q[i];
      // Direction comes from val sampled on the same edge as the tick, so a
      // reversal simply continues from the current brightness.
      if (tick) begin
        if (val[i] && bri_q[i] != MAX)
          bri_d[i] = sat_inc(bri_q[i]);
        else if (!val[i] && bri_q[i] != '0)
          bri_d[i] = sat_dec(bri_q[i]);
      end
      // Endpoint is all-ones for val=1 and zero for val=0.
      settled_d[i] = (bri_d[i] == {PWM_W{val[i]}});
      // Only a real move that lands on the endpoint counts as an arrival.
      arrive_d[i]  = tick && (bri_d[i] != bri_q[i]) && settled_d[i];
      // Full scale forced on so there is no dropout when pwm_cnt hits MAX.
      led_d[i]     = (bri_q[i] == MAX) || (bri_q[i] > pwm_cnt_q);
    end
    busy_d = ~&settled_d;
  end

  // Register stage: brightness, PWM counter and all outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_cnt_q <= '0;
      for (int i = 0; i < N; i++) bri_q[i] <= '0;
      led_q     <= '0;
      settled_q <= '1;
      arrive_q  <= '0;
      busy_q    <= 1'b0;
    end else begin
      pwm_cnt_q <= pwm_cnt_d;
      for (int i = 0; i < N; i++) bri_q[i] <= bri_d[i];
      led_q     <= led_d;
      settled_q <= settled_d;
      arrive_q  <= arrive_d;
      busy_q    <= busy_d;
    end
  end

  assign led     = led_q;
  assign settled = settled_q;
  assign arrive  = arrive_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_led_fade_driver.sv
module tb_led_fade_driver;

  localparam int N     = 3;
  localparam int STEP  = 16;
  localparam int MAXV  = 255;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         tick = 1'b0;
  logic [N-1:0] val = '0;
  logic [N-1:0] led, settled, arrive;
  logic         busy;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  int         m_bri [N];
  int         m_pwm;
  logic [N-1:0] m_led, m_settled, m_arrive;
  logic       m_busy;

  led_fade_driver #(.N(N), .PWM_W(8), .STEP(STEP)) dut (
    .clk(clk), .rst(rst), .tick(tick), .val(val),
    .led(led), .settled(settled), .arrive(arrive), .busy(busy)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs, advance the model across the edge, then
  // leave time 1ns after the edge for sampling.
  task automatic step(input logic r, input logic t, input logic [N-1:0] v);
    int nb;
    @(negedge clk);
    rst = r; tick = t; val = v;
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < N; i++) m_bri[i] = 0;
      m_pwm = 0; m_led = '0; m_settled = '1; m_arrive = '0; m_busy = 1'b0;
    end else begin
      for (int i = 0; i < N; i++) begin
        m_led[i] = (m_bri[i] == MAXV) || (m_bri[i] > m_pwm);
        nb = m_bri[i];
        if (t) begin
          if (v[i]) nb = (m_bri[i] + STEP > MAXV) ? MAXV : m_bri[i] + STEP;
          else      nb = (m_bri[i] - STEP < 0) ? 0 : m_bri[i] - STEP;
        end
        m_settled[i] = (nb == (v[i] ? MAXV : 0));
        m_arrive[i]  = t && (nb != m_bri[i]) && m_settled[i];
        m_bri[i] = nb;
      end
      m_pwm  = (m_pwm + 1) % 256;
      m_busy = (m_settled != '1);
    end
    #1;
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, '0);
    step(1'b1, 1'b0, '0);
  endtask

  task automatic test_reset();
    for (int k = 0; k < 3; k++) step(1'b1, 1'b1, 3'b111);
    checks++;
    if (led !== 3'b000) begin errors++; $display("FAIL reset_led got %b want 000", led); end
    checks++;
    if (settled !== 3'b111) begin errors++; $display("FAIL reset_settled got %b want 111", settled); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++;
    if (arrive !== 3'b000) begin errors++; $display("FAIL reset_arrive got %b want 000", arrive); end
    step(1'b0, 1'b0, 3'b111);
    checks++;
    if (settled !== 3'b000 || busy !== 1'b1) begin
      errors++; $display("FAIL release_settled got %b/%b want 000/1", settled, busy);
    end
  endtask

  task automatic test_fade_in();
    int cnt;
    do_reset();
    for (int k = 1; k <= 16; k++) begin
      step(1'b0, 1'b1, 3'b001);
      checks++;
      if (arrive[0] !== (k == 16)) begin
        errors++; $display("FAIL fade_in_arrive tick %0d got %b want %b", k, arrive[0], (k == 16));
      end
      checks++;
      if (settled[0] !== (k == 16) || busy !== (k != 16)) begin
        errors++; $display("FAIL fade_in_settled tick %0d got %b/%b want %b/%b",
                           k, settled[0], busy, (k == 16), (k != 16));
      end
      if (k[0]) step(1'b0, 1'b0, 3'b001);
    end
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 1'b1, 3'b001);
      checks++;
      if (arrive[0] !== 1'b0 || settled[0] !== 1'b1) begin
        errors++; $display("FAIL fade_in_hold got %b/%b want 0/1", arrive[0], settled[0]);
      end
    end
    cnt = 0;
    for (int k = 0; k < 256; k++) begin step(1'b0, 1'b0, 3'b001); cnt += int'(led[0]); end
    checks++;
    if (cnt != 256) begin errors++; $display("FAIL fade_in_duty got %0d want 256", cnt); end
  endtask

  task automatic test_duty();
    int cnt;
    do_reset();
    for (int k = 0; k < 4; k++) step(1'b0, 1'b1, 3'b010);
    cnt = 0;
    for (int k = 0; k < 256; k++) begin step(1'b0, 1'b0, 3'b010); cnt += int'(led[1]); end
    checks++;
    if (cnt != 64) begin errors++; $display("FAIL duty64 got %0d want 64", cnt); end
    for (int k = 0; k < 12; k++) step(1'b0, 1'b1, 3'b010);
    cnt = 0;
    for (int k = 0; k < 256; k++) begin step(1'b0, 1'b0, 3'b010); cnt += int'(led[1]); end
    checks++;
    if (cnt != 256) begin errors++; $display("FAIL duty255 got %0d want 256", cnt); end
    for (int k = 0; k < 16; k++) step(1'b0, 1'b1, 3'b000);
    cnt = 0;
    for (int k = 0; k < 256; k++) begin step(1'b0, 1'b0, 3'b000); cnt += int'(led[1]); end
    checks++;
    if (cnt != 0) begin errors++; $display("FAIL duty0 got %0d want 0", cnt); end
  endtask

  task automatic test_reversal();
    int cnt;
    do_reset();
    for (int k = 0; k < 5; k++) step(1'b0, 1'b1, 3'b100);
    cnt = 0;
    for (int k = 0; k < 256; k++) begin step(1'b0, 1'b0, 3'b100); cnt += int'(led[2]); end
    checks++;
    if (cnt != 80) begin errors++; $display("FAIL reversal_peak got %0d want 80", cnt); end
    for (int k = 1; k <= 5; k++) begin
      step(1'b0, 1'b1, 3'b000);
      checks++;
      if (arrive[2] !== (k == 5) || settled[2] !== (k == 5)) begin
        errors++; $display("FAIL reversal_tick %0d got %b/%b want %b/%b",
                           k, arrive[2], settled[2], (k == 5), (k == 5));
      end
      if (k == 2) begin
        cnt = 0;
        for (int j = 0; j < 256; j++) begin step(1'b0, 1'b0, 3'b000); cnt += int'(led[2]); end
        checks++;
        if (cnt != 48) begin errors++; $display("FAIL reversal_mid got %0d want 48", cnt); end
      end
    end
  endtask

  task automatic test_simultaneous();
    int cnt;
    do_reset();
    for (int k = 0; k < 16; k++) step(1'b0, 1'b1, 3'b001);
    step(1'b0, 1'b1, 3'b000);
    checks++;
    if (settled[0] !== 1'b0 || busy !== 1'b1 || arrive[0] !== 1'b0) begin
      errors++; $display("FAIL simul_flip got s%b b%b a%b want s0 b1 a0", settled[0], busy, arrive[0]);
    end
    cnt = 0;
    for (int k = 0; k < 256; k++) begin step(1'b0, 1'b0, 3'b000); cnt += int'(led[0]); end
    checks++;
    if (cnt != 239) begin errors++; $display("FAIL simul_duty got %0d want 239", cnt); end
  endtask

  task automatic test_reset_mid_fade();
    int guard;
    int cnt;
    do_reset();
    for (int k = 0; k < 8; k++) step(1'b0, 1'b1, 3'b001);
    guard = 0;
    while (m_pwm != 77 && guard < 300) begin step(1'b0, 1'b0, 3'b001); guard++; end
    checks++;
    if (m_pwm != 77) begin errors++; $display("FAIL mid_reset_align got %0d want 77", m_pwm); end
    step(1'b1, 1'b1, 3'b001);
    checks++;
    if (led !== 3'b000 || arrive !== 3'b000 || settled !== 3'b111 || busy !== 1'b0) begin
      errors++; $display("FAIL mid_reset got l%b a%b s%b b%b want l000 a000 s111 b0",
                         led, arrive, settled, busy);
    end
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      step(1'b0, 1'($urandom_range(0, 1)), 3'b000);
      if (arrive !== 3'b000) cnt++;
    end
    checks++;
    if (cnt != 0) begin errors++; $display("FAIL mid_reset_arrive got %0d pulses want 0", cnt); end
  endtask

  task automatic test_random();
    logic       r, t;
    logic [N-1:0] v;
    v = '0;
    for (int k = 0; k < 3000; k++) begin
      r = ($urandom_range(0, 499) == 0);
      t = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 39) == 0) v = N'($urandom);
      step(r, t, v);
      checks++;
      if (led !== m_led || settled !== m_settled || arrive !== m_arrive || busy !== m_busy) begin
        errors++;
        $display("FAIL random cyc %0d got l%b s%b a%b b%b want l%b s%b a%b b%b",
                 k, led, settled, arrive, busy, m_led, m_settled, m_arrive, m_busy);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fade_in();
    test_duty();
    test_reversal();
    test_simultaneous();
    test_reset_mid_fade();
    do_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
